ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 91 +++++++++
 tb/tb_ifu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// ifu: instruction fetch unit with a 2-entry prefetch FIFO, in front of a 1-cycle-latency instruction SRAM.
// Define IFU_PERF_EN to enable the delivered-instruction and bubble-cycle counters.
module ifu #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_en_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ls_hold_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
);
    logic [31:0] r_fetch_pc, r_inflight_pc, r_last_pc;
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc [2];
    logic [1:0]  r_cnt;
    logic        r_inflight;
    logic        w_empty, w_pop, w_push, w_req, w_wr_idx, w_unused;
    logic [2:0]  w_occ;

    assign w_empty  = r_cnt == 2'd0;
    assign w_pop    = !w_empty && !ls_hold_i && !jump_i;
    assign w_push   = r_inflight && !jump_i;
    // Occupancy after this cycle's pop, counting the response still on its way.
    assign w_occ    = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_req    = !rst && (jump_i || w_occ < 3'd2);
    assign w_wr_idx = (r_cnt - {1'b0, w_pop}) != 2'd0;
    assign w_unused = ^jump_addr_i[1:0];

    assign rom_en_o   = w_req;
    assign rom_addr_o = jump_i ? {jump_addr_i[31:2], 2'b00} : r_fetch_pc;
    assign instr_o    = (rst || w_empty) ? NOP_INSTR : r_fifo_instr[0];
    assign pc_o       = rst ? RESET_PC : w_empty ? r_last_pc : r_fifo_pc[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 2'd0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
            r_last_pc     <= RESET_PC;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc <= rom_addr_o;
                r_fetch_pc    <= rom_addr_o + 32'd4;
            end
            if (jump_i) begin
                r_cnt <= 2'd0;
            end else begin
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
                if (w_pop) begin
                    r_fifo_instr[0] <= r_fifo_instr[1];
                    r_fifo_pc[0]    <= r_fifo_pc[1];
                    r_last_pc       <= r_fifo_pc[0];
                end
                if (w_push) begin
                    r_fifo_instr[w_wr_idx] <= rom_data_i;
                    r_fifo_pc[w_wr_idx]    <= r_inflight_pc;
                end
            end
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] r_fetch_cnt, r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_empty && !ls_hold_i && !jump_i) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o  = r_fetch_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`else
    assign fetch_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed scenarios plus a randomized run, checked against an in-order stream model of the fetch unit.
module tb_ifu;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_en_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i = 32'hDEAD_BEEF;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        ls_hold_i = 1'b0;
    logic [31:0] instr_o, pc_o, fetch_cnt_o, bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    // stream model state
    logic [31:0] exp_pc = '0;
    logic [31:0] last_pc = '0;
    int m_fetch = 0;
    int m_bubble = 0;
    int delivered = 0;

    ifu dut (
        .clk(clk), .rst(rst), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i), .ls_hold_i(ls_hold_i), .instr_o(instr_o),
        .pc_o(pc_o), .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[31:2] ^ 30'h15A5_3C3C, 2'b01};
    endfunction

    always @(posedge clk) rom_data_i <= rom_en_o ? mem(rom_addr_o) : 32'hDEAD_BEEF;

    // Every delivered instruction must be the next address of the program order, with the right data.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = 32'h0; last_pc = 32'h0; m_fetch = 0; m_bubble = 0;
        end else begin
            if (rom_en_o) begin
                checks++;
                if (rom_addr_o[1:0] !== 2'b00) begin errors++; $display("FAIL rom_addr_align: got %h", rom_addr_o); end
            end
            if (instr_o === NOP) begin
                checks++;
                if (pc_o !== last_pc) begin errors++; $display("FAIL empty_pc: got %h expected %h", pc_o, last_pc); end
                if (!ls_hold_i && !jump_i) m_bubble++;
            end else begin
                checks++;
                if (pc_o !== exp_pc) begin errors++; $display("FAIL stream_pc: got %h expected %h", pc_o, exp_pc); end
                checks++;
                if (instr_o !== mem(pc_o)) begin errors++; $display("FAIL stream_instr: got %h expected %h", instr_o, mem(pc_o)); end
                if (!ls_hold_i && !jump_i) begin
                    last_pc = pc_o; exp_pc = pc_o + 32'd4; m_fetch++; delivered++;
                end
            end
            if (jump_i) exp_pc = {jump_addr_i[31:2], 2'b00};
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; jump_i = 1'b0; ls_hold_i = 1'b0;
        repeat (3) tick();
        #1;
        checks++; if (rom_en_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", rom_en_o); end
        checks++; if (instr_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr_o, NOP); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_o); end
        checks++; if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_fetch_cnt: got %h expected 0", fetch_cnt_o); end
        checks++; if (bubble_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_bubble_cnt: got %h expected 0", bubble_cnt_o); end
    endtask

    task automatic test_first_fetch();
        tick();
        rst = 1'b0; #1;
        checks++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'h0) begin errors++; $display("FAIL first_req: got en=%b addr=%h expected en=1 addr=0", rom_en_o, rom_addr_o); end
        tick();
        checks++; if (instr_o !== NOP) begin errors++; $display("FAIL first_nop: got %h expected %h", instr_o, NOP); end
        tick();
        checks++; if (instr_o !== 32'h0050_0093 || pc_o !== 32'h0) begin errors++; $display("FAIL first_instr: got %h@%h expected 00500093@0", instr_o, pc_o); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (pc_o !== 32'(4 * k) || instr_o !== mem(32'(4 * k))) begin
                errors++; $display("FAIL stream_%0d: got %h@%h expected %h@%h", k, instr_o, pc_o, mem(32'(4 * k)), 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [31:0] p, ins;
        ls_hold_i = 1'b1; #1;
        p = pc_o; ins = instr_o;
        checks++; if (p !== 32'h20) begin errors++; $display("FAIL hold_entry_pc: got %h expected 20", p); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (pc_o !== p || instr_o !== ins) begin errors++; $display("FAIL hold_stable_%0d: got %h@%h expected %h@%h", k, instr_o, pc_o, ins, p); end
            checks++; if (rom_en_o !== 1'b0) begin errors++; $display("FAIL hold_no_req_%0d: got %b expected 0", k, rom_en_o); end
            if (k < 2) tick();
        end
        tick();
        ls_hold_i = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (pc_o !== p + 32'(4 * k)) begin errors++; $display("FAIL hold_resume_%0d: got %h expected %h", k, pc_o, p + 32'(4 * k)); end
            tick();
        end
    endtask

    task automatic test_jump(input logic [31:0] tgt, input logic with_hold);
        logic [31:0] a;
        a = {tgt[31:2], 2'b00};
        jump_i = 1'b1; jump_addr_i = tgt; ls_hold_i = with_hold; #1;
        checks++; if (rom_en_o !== 1'b1 || rom_addr_o !== a) begin errors++; $display("FAIL jump_req: got en=%b addr=%h expected en=1 addr=%h", rom_en_o, rom_addr_o, a); end
        tick();
        jump_i = 1'b0; ls_hold_i = 1'b0; #1;
        checks++; if (instr_o !== NOP) begin errors++; $display("FAIL jump_nop: got %h expected %h", instr_o, NOP); end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pc_o !== a + 32'(4 * k) || instr_o !== mem(a + 32'(4 * k))) begin
                errors++; $display("FAIL jump_stream_%0d: got %h@%h expected %h@%h", k, instr_o, pc_o, mem(a + 32'(4 * k)), a + 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        rst = 1'b1; #1;
        checks++; if (rom_en_o !== 1'b0) begin errors++; $display("FAIL rst_mid_en: got %b expected 0", rom_en_o); end
        tick();
        rst = 1'b0; #1;
        checks++; if (instr_o !== NOP || pc_o !== 32'h0) begin errors++; $display("FAIL rst_mid_flush: got %h@%h expected %h@0", instr_o, pc_o, NOP); end
        checks++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'h0) begin errors++; $display("FAIL rst_mid_req: got en=%b addr=%h expected en=1 addr=0", rom_en_o, rom_addr_o); end
        tick();
        checks++; if (instr_o !== NOP) begin errors++; $display("FAIL rst_mid_discard: got %h expected %h", instr_o, NOP); end
        tick();
        checks++; if (instr_o !== 32'h0050_0093 || pc_o !== 32'h0) begin errors++; $display("FAIL rst_mid_restart: got %h@%h expected 00500093@0", instr_o, pc_o); end
    endtask

    task automatic test_random();
        int start;
        start = delivered;
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(99) == 0);
            jump_i = ($urandom_range(19) == 0);
            jump_addr_i = $urandom;
            ls_hold_i = ($urandom_range(9) < 3);
            tick();
        end
        rst = 1'b0; jump_i = 1'b0; ls_hold_i = 1'b0;
        tick();
        checks++; if (delivered - start < 150) begin errors++; $display("FAIL random_progress: got %0d deliveries expected at least 150", delivered - start); end
`ifdef IFU_PERF_EN
        checks++; if (fetch_cnt_o !== 32'(m_fetch)) begin errors++; $display("FAIL random_fetch_cnt: got %0d expected %0d", fetch_cnt_o, m_fetch); end
        checks++; if (bubble_cnt_o !== 32'(m_bubble)) begin errors++; $display("FAIL random_bubble_cnt: got %0d expected %0d", bubble_cnt_o, m_bubble); end
`endif
    endtask

    task automatic test_perf();
        logic [31:0] ef, eb;
        rst = 1'b1; jump_i = 1'b0; ls_hold_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (7) tick();
        jump_i = 1'b1; jump_addr_i = 32'h40;
        tick();
        jump_i = 1'b0;
        repeat (6) tick();
        ls_hold_i = 1'b1; #1;
`ifdef IFU_PERF_EN
        ef = 32'd10; eb = 32'd3;
`else
        ef = 32'd0; eb = 32'd0;
`endif
        checks++; if (fetch_cnt_o !== ef) begin errors++; $display("FAIL perf_fetch_cnt: got %0d expected %0d", fetch_cnt_o, ef); end
        checks++; if (bubble_cnt_o !== eb) begin errors++; $display("FAIL perf_bubble_cnt: got %0d expected %0d", bubble_cnt_o, eb); end
        checks++; if (m_fetch != 10 || m_bubble != 3) begin errors++; $display("FAIL perf_scenario: got %0d/%0d expected 10/3", m_fetch, m_bubble); end
        ls_hold_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stream();
        test_hold();
        test_jump(32'h0000_0103, 1'b0);
        test_jump(32'hFFFF_FFF9, 1'b0);
        test_jump($urandom, 1'b1);
        test_reset_midstream();
        test_random();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
